// File: rtl/pad_filter_pkg.sv
// Shared types and helpers for the pad input conditioning path.
// Imported by pad_input_filter and pad_input_sync.
package pad_filter_pkg;

  localparam int unsigned GLITCH_CNT_W = 8;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } filt_state_e;

  // True when a commit towards new_level is one the selector asks to report.
  function automatic logic edge_match(input edge_sel_e sel, input logic new_level);
    logic match;
    match = 1'b0;
    case (sel)
      EDGE_RISE: match = new_level;
      EDGE_FALL: match = ~new_level;
      EDGE_BOTH: match = 1'b1;
      default:   match = 1'b0;
    endcase
    return match;
  endfunction

  function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] val);
    return (&val) ? val : val + GLITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pad_input_sync.sv
// Multi-flop synchroniser bringing the raw asynchronous pad value into clk_i.
// The D input of the first stage is the only asynchronous crossing in the block.
module pad_input_sync
  import pad_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pad_input_filter.sv
// Pad input conditioner: synchronise, debounce with a programmable window and
// report a clean level, a selectable edge pulse, a sticky pending flag and glitches.
module pad_input_filter
  import pad_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    pad_i,
  input  logic                    en_i,
  input  logic [CNT_W-1:0]        debounce_cycles_i,
  input  logic [1:0]              edge_sel_i,
  input  logic                    clr_i,
  output logic                    level_o,
  output logic                    edge_o,
  output logic                    pending_o,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

  logic sync;

  pad_input_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (RESET_VAL)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pad_i),
    .q_o    (sync)
  );

  filt_state_e             state_q,   state_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    level_q,   level_d;
  logic                    edge_q,    edge_d;
  logic                    pending_q, pending_d;
  logic [GLITCH_CNT_W-1:0] glitch_q,  glitch_d;
  logic                    commit;
  logic                    glitch;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    commit  = 1'b0;
    glitch  = 1'b0;

    if (!en_i) begin
      // Bypass: track the synchronised value so re-enabling starts matched.
      state_d = STABLE;
      cnt_d   = '0;
      level_d = sync;
    end else begin
      case (state_q)
        STABLE: begin
          if (sync != level_q) begin
            if (debounce_cycles_i == '0) begin
              commit = 1'b1;
            end else begin
              state_d = CHECK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (sync == level_q) begin
            glitch  = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= debounce_cycles_i) begin
            // >= lets a threshold lowered mid-window commit immediately.
            commit  = 1'b1;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
      if (commit) begin
        level_d = sync;
      end
    end
  end

  always_comb begin
    edge_d = commit && edge_match(edge_sel_e'(edge_sel_i), sync);

    // Set beats clear for the sticky flag.
    pending_d = pending_q;
    if (clr_i) pending_d = 1'b0;
    if (edge_q) pending_d = 1'b1;

    // Clear first, then count, so a coincident glitch lands on 1.
    glitch_d = glitch_q;
    if (clr_i) glitch_d = '0;
    if (glitch) glitch_d = sat_inc(glitch_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= STABLE;
      cnt_q     <= '0;
      level_q   <= RESET_VAL;
      edge_q    <= 1'b0;
      pending_q <= 1'b0;
      glitch_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      edge_q    <= edge_d;
      pending_q <= pending_d;
      glitch_q  <= glitch_d;
    end
  end

  assign level_o      = level_q;
  assign edge_o       = edge_q;
  assign pending_o    = pending_q;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_pad_input_filter.sv
// Directed self-checking bench for pad_input_filter (SYNC_STAGES=2, CNT_W=16).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_pad_input_filter;

  logic        clk;
  logic        rst_ni;
  logic        pad;
  logic        en;
  logic [15:0] n_thr;
  logic [1:0]  edge_sel;
  logic        clr;
  logic        level;
  logic        edge_p;
  logic        pending;
  logic [7:0]  glitch_cnt;

  int total = 0;
  int bad   = 0;

  pad_input_filter #(
    .SYNC_STAGES (2),
    .CNT_W       (16),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .pad_i             (pad),
    .en_i              (en),
    .debounce_cycles_i (n_thr),
    .edge_sel_i        (edge_sel),
    .clr_i             (clr),
    .level_o           (level),
    .edge_o            (edge_p),
    .pending_o         (pending),
    .glitch_cnt_o      (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pad high for two cycles then low; with N=3 this is rejected as a glitch.
  // Optionally asserts clr_i on the exact cycle the glitch is registered.
  task automatic glitch_pulse(input bit clr_on_glitch);
    pad = 1'b1;
    tick(2);
    pad = 1'b0;
    tick(2);
    if (clr_on_glitch) clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; pad = 1'b0; en = 1'b1; n_thr = 16'd3; edge_sel = 2'b01; clr = 1'b0;
    #2;
    total++;
    if ({level, edge_p, pending} !== 3'b000 || glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: got level=%b edge=%b pending=%b glitch=%0d expected 0 0 0 0",
               level, edge_p, pending, glitch_cnt);
    end
    tick(2);
    rst_ni = 1'b1;
    tick(3);
    total++;
    if (level !== 1'b0 || edge_p !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got level=%b edge=%b expected 0 0", level, edge_p);
    end
  endtask

  task automatic test_glitch;
    n_thr = 16'd3;
    glitch_pulse(1'b0);
    total++;
    if (glitch_cnt !== 8'd1 || level !== 1'b0) begin
      bad++;
      $display("FAIL glitch_first: got cnt=%0d level=%b expected cnt=1 level=0", glitch_cnt, level);
    end
    for (int i = 2; i <= 255; i++) glitch_pulse(1'b0);
    total++;
    if (glitch_cnt !== 8'd255) begin
      bad++;
      $display("FAIL glitch_reach_255: got %0d expected 255", glitch_cnt);
    end
    for (int i = 256; i <= 300; i++) begin
      glitch_pulse(1'b0);
      total++;
      if (level !== 1'b0) begin
        bad++;
        $display("FAIL glitch_level_hold: pulse %0d got level=%b expected 0", i, level);
      end
    end
    total++;
    if (glitch_cnt !== 8'd255 || pending !== 1'b0) begin
      bad++;
      $display("FAIL glitch_saturate: got cnt=%0d pending=%b expected cnt=255 pending=0",
               glitch_cnt, pending);
    end
    glitch_pulse(1'b1);
    total++;
    if (glitch_cnt !== 8'd1) begin
      bad++;
      $display("FAIL glitch_clr_coincident: got %0d expected 1", glitch_cnt);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL glitch_clear: got %0d expected 0", glitch_cnt);
    end
  endtask

  task automatic test_rising;
    n_thr = 16'd3; edge_sel = 2'b01;
    pad = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      total++;
      if (level !== (i == 6) || edge_p !== (i == 6)) begin
        bad++;
        $display("FAIL rise_latency: cycle %0d got level=%b edge=%b expected %b %b",
                 i, level, edge_p, (i == 6), (i == 6));
      end
    end
    tick(1);
    total++;
    if (edge_p !== 1'b0 || pending !== 1'b1 || level !== 1'b1) begin
      bad++;
      $display("FAIL rise_after: got edge=%b pending=%b level=%b expected 0 1 1", edge_p, pending, level);
    end
  endtask

  task automatic test_edge_sel_zero;
    edge_sel = 2'b00; n_thr = 16'd0; pad = 1'b0;
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (level !== 1'b0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL sel_none_fall: got level=%b pending=%b expected 0 0", level, pending);
    end
    edge_sel = 2'b10;
    pad = 1'b1;
    tick(2);
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL n0_rise_early: got level=%b expected 0", level);
    end
    tick(1);
    total++;
    if (level !== 1'b1 || edge_p !== 1'b0) begin
      bad++;
      $display("FAIL n0_rise_commit: got level=%b edge=%b expected 1 0", level, edge_p);
    end
    tick(2);
    pad = 1'b0;
    tick(2);
    total++;
    if (level !== 1'b1 || edge_p !== 1'b0) begin
      bad++;
      $display("FAIL n0_fall_early: got level=%b edge=%b expected 1 0", level, edge_p);
    end
    tick(1);
    total++;
    if (level !== 1'b0 || edge_p !== 1'b1) begin
      bad++;
      $display("FAIL n0_fall_commit: got level=%b edge=%b expected 0 1", level, edge_p);
    end
    tick(1);
    total++;
    if (edge_p !== 1'b0 || pending !== 1'b1) begin
      bad++;
      $display("FAIL n0_fall_after: got edge=%b pending=%b expected 0 1", edge_p, pending);
    end
  endtask

  // Pad value set in step j reaches level_o after step j+2 (2 sync stages + 1).
  task automatic test_back_to_back;
    bit pat [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit exp_lvl, prev_lvl;
    n_thr = 16'd0; edge_sel = 2'b11;
    prev_lvl = 1'b0;
    for (int j = 0; j < 12; j++) begin
      pad = pat[j];
      tick(1);
      exp_lvl = (j >= 2) ? pat[j-2] : 1'b0;
      total++;
      if (level !== exp_lvl || edge_p !== (exp_lvl != prev_lvl)) begin
        bad++;
        $display("FAIL b2b_step%0d: got level=%b edge=%b expected %b %b",
                 j, level, edge_p, exp_lvl, (exp_lvl != prev_lvl));
      end
      prev_lvl = exp_lvl;
    end
  endtask

  task automatic test_threshold_clear;
    n_thr = 16'd10; edge_sel = 2'b01;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    pad = 1'b1;
    tick(6);
    total++;
    if (level !== 1'b0 || pending !== 1'b0) begin
      bad++;
      $display("FAIL thr_window: got level=%b pending=%b expected 0 0", level, pending);
    end
    n_thr = 16'd2;
    tick(1);
    total++;
    if (level !== 1'b1 || edge_p !== 1'b1) begin
      bad++;
      $display("FAIL thr_lowered_commit: got level=%b edge=%b expected 1 1", level, edge_p);
    end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    total++;
    if (pending !== 1'b1 || edge_p !== 1'b0) begin
      bad++;
      $display("FAIL pending_set_wins: got pending=%b edge=%b expected 1 0", pending, edge_p);
    end
  endtask

  task automatic test_enable;
    bit pat [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit exp_lvl;
    en = 1'b0; edge_sel = 2'b11; n_thr = 16'd3;
    for (int j = 0; j < 10; j++) begin
      pad = pat[j];
      tick(1);
      exp_lvl = (j >= 2) ? pat[j-2] : 1'b1;
      total++;
      if (level !== exp_lvl || edge_p !== 1'b0) begin
        bad++;
        $display("FAIL dis_follow_step%0d: got level=%b edge=%b expected %b 0", j, level, edge_p, exp_lvl);
      end
    end
    total++;
    if (glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL dis_no_glitch: got %0d expected 0", glitch_cnt);
    end
    en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      total++;
      if (edge_p !== 1'b0 || level !== 1'b0) begin
        bad++;
        $display("FAIL reenable_quiet%0d: got edge=%b level=%b expected 0 0", j, edge_p, level);
      end
    end
  endtask

  task automatic test_reset_mid_check;
    n_thr = 16'd3;
    glitch_pulse(1'b0);
    total++;
    if (glitch_cnt !== 8'd1 || pending !== 1'b1) begin
      bad++;
      $display("FAIL prereset_state: got cnt=%0d pending=%b expected 1 1", glitch_cnt, pending);
    end
    n_thr = 16'd10; edge_sel = 2'b01;
    pad = 1'b1;
    tick(5);
    rst_ni = 1'b0;
    #2;
    total++;
    if ({level, edge_p, pending} !== 3'b000 || glitch_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid_check: got level=%b edge=%b pending=%b glitch=%0d expected 0 0 0 0",
               level, edge_p, pending, glitch_cnt);
    end
    tick(1);
    rst_ni = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick(1);
      total++;
      if (level !== (i == 13) || edge_p !== (i == 13)) begin
        bad++;
        $display("FAIL post_reset_window: cycle %0d got level=%b edge=%b expected %b %b",
                 i, level, edge_p, (i == 13), (i == 13));
      end
    end
    tick(1);
    total++;
    if (pending !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_pending: got %b expected 1", pending);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rising();
    test_edge_sel_zero();
    test_back_to_back();
    test_threshold_clear();
    test_enable();
    test_reset_mid_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pad_input_filter.md
# pad_input_filter

Conditioning stage directly downstream of `pad_cell_input`: takes the raw, asynchronous pad value, synchronises it into `clk_i`, debounces it with a programmable stability window and produces a clean level, a single-cycle edge pulse, a sticky pending flag and a saturating glitch count. It sits between the pad ring and consumers of the pad input, such as GPIO, wake-up and interrupt logic.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `CNT_W`, 16: width of the debounce counter and threshold.
- `RESET_VAL`, 1'b0: reset value of the synchroniser flops and of `level_o`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `pad_i`  in  1  raw pad value (`pad_out_o` of the pad cell); asynchronous.
- `en_i`  in  1  filter enable.
- `debounce_cycles_i`  in  CNT_W  threshold N. A new value must be sampled N+1 consecutive cycles to be committed.
- `edge_sel_i`  in  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
- `clr_i`  in  1  clears `pending_o` and `glitch_cnt_o`.
- `level_o`  out  1  debounced level (registered).
- `edge_o`  out  1  one-cycle pulse on a selected committed edge.
- `pending_o`  out  1  sticky, set by `edge_o`.
- `glitch_cnt_o`  out  8  saturating count of rejected transitions.

## Operation
- Reset values:
  - sync chain = `RESET_VAL`, `level_o` = `RESET_VAL`.
  - FSM = STABLE, counter = 0.
  - `edge_o` = 0, `pending_o` = 0, `glitch_cnt_o` = 0.
- `sync` is the last stage of the synchroniser. The chain runs regardless of `en_i`.
- FSM states: STABLE, CHECK.
- STABLE:
  - `sync == level_o`: stay.
  - Mismatch and N==0: commit this cycle (`level_o <= sync`), stay in STABLE.
  - Mismatch and N>0: go to CHECK, counter <= 1.
- CHECK:
  - `sync == level_o`: glitch. Go to STABLE, counter <= 0, `glitch_cnt_o` += 1, saturating at 255.
  - Else, counter ≥ N: commit, go to STABLE, counter <= 0. Uses ≥ so that lowering N mid-window commits on the next cycle.
  - Else: counter += 1. Counter never wraps; it is bounded by the ≥ compare.
- Commit:
  - `level_o` takes the new value.
  - `edge_o` = 1 for exactly that cycle, if the transition direction matches `edge_sel_i`.
- `en_i` = 0:
  - FSM forced to STABLE, counter 0.
  - `level_o` follows `sync` every cycle.
  - `edge_o` held 0; no glitch counting.
  - Re-enabling therefore never produces a spurious edge.
- `pending_o`:
  - Set on `edge_o`, cleared on `clr_i`.
  - Simultaneous set and clear: set wins.
- `glitch_cnt_o`:
  - `clr_i` zeroes it.
  - Simultaneous clear and glitch: result is 1.
- `edge_sel_i` is sampled at commit time only. Changing it never retro-generates edges.

## Timing
- Pad change stable before edge k:
  - `sync` changes after edge k+SYNC_STAGES−1.
  - `level_o` and `edge_o` change after edge k+SYNC_STAGES+N.
  - Total latency: SYNC_STAGES+N+1 cycles.
- `edge_o` is registered and coincident with the `level_o` change; width exactly 1 cycle.
- `pending_o` rises one cycle after `edge_o`.
- Minimum spacing between two commits is 1 cycle (N=0). A toggling `sync` with N=0 commits every cycle.
- Reset asserted mid-CHECK: all state returns to reset values immediately. After deassertion, a pad value differing from `RESET_VAL` goes through a full debounce window and produces an edge.

## Structure
- Package `pad_filter_pkg`:
  - `edge_sel_e` (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
  - `filt_state_e` (STABLE, CHECK).
  - `GLITCH_CNT_W` = 8.
- Sub-module `pad_input_sync`: parameterised SYNC_STAGES flop chain with reset value `RESET_VAL`, async active-low reset. This is the only instance of asynchronous input handling; the FPGA flow constrains it as a false path on its D input.
- The FSM, counter, edge logic and sticky/glitch registers live in `pad_input_filter`.

## Test plan
- **Clean rising edge.** N=3, edge_sel=01, `pad_i` 0→1 held. Required:
  - `level_o` rises exactly SYNC_STAGES+4 cycles later.
  - `edge_o` is high for 1 cycle.
  - `pending_o` = 1 the next cycle.
- **Glitch rejection.** N=3, `pad_i` high for 2 cycles then low. Required: `level_o` stays 0, no `edge_o`, `glitch_cnt_o` = 1. Repeat 300 times: `glitch_cnt_o` saturates at 255.
- **Edge select and zero threshold.** N=0, edge_sel=10, pad toggles 0→1→0 with 5-cycle gaps. Required: both level changes occur, `edge_o` only on the falling one.
- **Threshold change and clear.**
  - N=10, pad rises; at counter=4 set N=2. Required: commit on the next cycle.
  - `clr_i` coincident with `edge_o`. Required: `pending_o` = 1.
- **Enable and reset.**
  - `en_i` = 0, pad toggles. Required: `level_o` follows with no `edge_o`; enabling produces no edge.
  - `rst_ni` pulsed low mid-CHECK. Required: all outputs return to reset values within the reset cycle.
